// File: rtl/rank_filter.sv
// Rank-order filter: gathers a window of P unsigned W-bit samples from a
// strobed stream, sorts it with an odd-even transposition network (one pass
// per cycle) and emits the element at the rank latched with the last sample.
module rank_filter #(
   parameter  int W  = 8,
   parameter  int P  = 9,
   localparam int RW = $clog2(P)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [W-1:0]  DI,
   input  logic          DSI,
   input  logic [RW-1:0] RANK,
   output logic [W-1:0]  DO,
   output logic          DSO,
   output logic          BUSY
);

   localparam int CW = $clog2(P + 1);
   localparam int PW = $clog2(P);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SORT,
      S_OUT
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q [P];
   logic [W-1:0]    srt_d [P];
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   pc_q;
   logic [RW-1:0]   rsel_q;
   logic [W-1:0]    do_q;
   logic            dso_q;
   logic            busy_q;

   assign DO   = do_q;
   assign DSO  = dso_q;
   assign BUSY = busy_q;

   // One transposition pass: even pc pairs (0,1),(2,3)..., odd pc pairs (1,2),(3,4)...
   always_comb begin
      srt_d = a_q;
      for (int unsigned i = 0; i < $unsigned(P - 1); i++) begin
         if (i[0] == pc_q[0]) begin
            if (a_q[i] > a_q[i+1]) begin
               srt_d[i]   = a_q[i+1];
               srt_d[i+1] = a_q[i];
            end
         end
      end
   end

   // Control FSM, sample storage, sort passes and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         pc_q    <= '0;
         rsel_q  <= '0;
         do_q    <= '0;
         dso_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         dso_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (DSI) begin
                  a_q[cnt_q] <= DI;
                  if (cnt_q == CW'(P - 1)) begin
                     rsel_q  <= (RANK > RW'(P - 1)) ? RW'(P - 1) : RANK;
                     cnt_q   <= '0;
                     pc_q    <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_SORT;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_SORT: begin
               a_q <= srt_d;
               if (pc_q == PW'(P - 1)) begin
                  state_q <= S_OUT;
               end else begin
                  pc_q <= pc_q + 1'b1;
               end
            end
            S_OUT: begin
               do_q    <= a_q[rsel_q];
               dso_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_LOAD;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rank_filter.sv
// Self-checking bench for rank_filter: directed windows plus randomized
// windows compared against a sort-and-pick reference model.
module tb_rank_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst9, dsi9, dso9, busy9;
   logic [7:0]  di9, do9;
   logic [3:0]  rank9;

   logic        rst3, dsi3, dso3, busy3;
   logic [11:0] di3, do3;
   logic [1:0]  rank3;

   int n_cmp = 0;
   int n_err = 0;
   int dso_tot9 = 0;

   rank_filter dut9 (
      .CLK(clk), .RST(rst9), .DI(di9), .DSI(dsi9), .RANK(rank9),
      .DO(do9), .DSO(dso9), .BUSY(busy9)
   );

   rank_filter #(.W(12), .P(3)) dut3 (
      .CLK(clk), .RST(rst3), .DI(di3), .DSI(dsi3), .RANK(rank3),
      .DO(do3), .DSO(dso3), .BUSY(busy3)
   );

   // Count result strobes of the default-size instance.
   always @(posedge clk) if (dso9 === 1'b1) dso_tot9++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: sort the window ascending, pick the clamped rank.
   function automatic int model(input int vals[$], input int rank);
      int s[$];
      int r;
      s = vals;
      s.sort();
      r = (rank >= vals.size()) ? vals.size() - 1 : rank;
      return s[r];
   endfunction

   task automatic put(input int sel, input logic s, input int d);
      if (sel == 0) begin dsi9 = s; di9 = d[7:0]; end
      else          begin dsi3 = s; di3 = d[11:0]; end
   endtask

   task automatic set_rank(input int sel, input int r);
      if (sel == 0) rank9 = r[3:0];
      else          rank3 = r[1:0];
   endtask

   function automatic logic [31:0] obs_do(input int sel);
      return (sel == 0) ? 32'(do9) : 32'(do3);
   endfunction

   function automatic logic obs_dso(input int sel);
      return (sel == 0) ? dso9 : dso3;
   endfunction

   function automatic logic obs_busy(input int sel);
      return (sel == 0) ? busy9 : busy3;
   endfunction

   // Send one window, then check latency, busy length, result and strobe width.
   task automatic run_window(input int sel, input string tag, input int vals[$],
                             input int rank, input int maxgap, input int mid_rank,
                             input int junk);
      int p, exp, lat, busyc, g;
      p   = vals.size();
      exp = model(vals, rank);
      set_rank(sel, rank);
      foreach (vals[i]) begin
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         repeat (g) begin
            put(sel, 1'b0, 0);
            @(negedge clk);
         end
         put(sel, 1'b1, vals[i]);
         @(negedge clk);
      end
      put(sel, 1'b0, 0);
      lat   = 0;
      busyc = (obs_busy(sel) === 1'b1) ? 1 : 0;
      while (obs_dso(sel) !== 1'b1 && lat < 4 * p + 8) begin
         if (lat < junk) put(sel, 1'b1, 0);
         else            put(sel, 1'b0, 0);
         if (lat == 3 && mid_rank >= 0) set_rank(sel, mid_rank);
         @(negedge clk);
         lat++;
         if (obs_busy(sel) === 1'b1) busyc++;
      end
      put(sel, 1'b0, 0);
      check({tag, ".lat"}, lat, p + 1);
      check({tag, ".busy"}, busyc, p + 1);
      check({tag, ".do"}, obs_do(sel), exp);
      @(negedge clk);
      check({tag, ".dso_drop"}, 32'(obs_dso(sel)), 0);
      check({tag, ".do_hold"}, obs_do(sel), exp);
   endtask

   initial begin
      int base[$];
      int w[$];
      int c;
      base = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
      rst9 = 1'b1; dsi9 = 1'b0; di9 = '0; rank9 = '0;
      rst3 = 1'b1; dsi3 = 1'b0; di3 = '0; rank3 = '0;
      repeat (3) @(negedge clk);
      check("rst.do9", 32'(do9), 0);
      check("rst.dso9", 32'(dso9), 0);
      check("rst.busy9", 32'(busy9), 0);
      check("rst.do3", 32'(do3), 0);
      check("rst.busy3", 32'(busy3), 0);
      rst9 = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      run_window(0, "median", base, 4, 0, -1, 0);
      run_window(0, "min", base, 0, 0, -1, 0);
      run_window(0, "max", base, 8, 0, -1, 0);
      run_window(0, "clamp15", base, 15, 0, -1, 0);
      run_window(0, "rank_mid_sort", base, 4, 0, 0, 0);
      run_window(0, "gaps", base, 4, 3, -1, 0);
      run_window(0, "junk_busy", base, 4, 0, -1, 5);
      w = '{200, 200, 200, 200, 200, 200, 200, 200, 200};
      run_window(0, "after_junk", w, 4, 0, -1, 0);

      // Partial window discarded by reset.
      for (int i = 0; i < 5; i++) begin
         put(0, 1'b1, 77 + i);
         @(negedge clk);
      end
      put(0, 1'b0, 0);
      rst9 = 1'b1;
      @(negedge clk);
      rst9 = 1'b0;
      c = dso_tot9;
      w = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
      run_window(0, "rst_partial", w, 4, 0, -1, 0);
      repeat (5) @(negedge clk);
      check("rst_partial.dso_count", dso_tot9 - c, 1);

      // Reset in the middle of sorting.
      set_rank(0, 4);
      foreach (base[i]) begin
         put(0, 1'b1, base[i]);
         @(negedge clk);
      end
      put(0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst9 = 1'b1;
      @(negedge clk);
      rst9 = 1'b0;
      c = dso_tot9;
      repeat (20) @(negedge clk);
      check("rst_sort.dso_count", dso_tot9 - c, 0);
      check("rst_sort.do", 32'(do9), 0);
      check("rst_sort.busy", 32'(busy9), 0);

      w = '{31, 30, 29, 28, 27, 26, 25, 24, 23};
      run_window(0, "reversed", w, 4, 0, -1, 0);

      for (int k = 0; k < 15; k++) begin
         w = {};
         for (int i = 0; i < 9; i++) w.push_back(int'($urandom_range(255, 0)));
         run_window(0, "rand9", w, int'($urandom_range(15, 0)), 3, -1, 0);
      end

      w = '{4095, 0, 4095};
      run_window(1, "p3_ext", w, 1, 0, -1, 0);
      w = '{7, 7, 7};
      run_window(1, "p3_equal", w, 2, 0, -1, 0);
      w = '{3, 1, 2};
      run_window(1, "p3_clamp", w, 3, 0, -1, 0);
      for (int k = 0; k < 10; k++) begin
         w = {};
         for (int i = 0; i < 3; i++) w.push_back(int'($urandom_range(4095, 0)));
         run_window(1, "rand3", w, int'($urandom_range(3, 0)), 2, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
